// File: rtl/mix_columns_pkg.sv
// GF(2^8) helpers, coefficient rows and FSM encoding shared by the MixColumns engine.
// Pure declarations: no clocked logic, no handshake.
package mix_columns_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Circulant rows: output byte r takes row[(k - r) mod 4] for input byte k.
   localparam logic [0:3][7:0] FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
   localparam logic [0:3][7:0] INV_ROW = {8'h0e, 8'h0b, 8'h0d, 8'h09};

   function automatic logic [7:0] gf_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Every coefficient fits in four bits, so three doublings cover all terms.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = gf_xtime(b);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
   endfunction

   function automatic logic [0:31] mix_col(input logic [0:31] a, input logic [0:3][7:0] row);
      logic [0:31] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            r[8*i +: 8] = r[8*i +: 8] ^ gf_mul(a[8*k +: 8], row[2'(k - i)][3:0]);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mix_column_lane.sv
// One-column MixColumns / InvMixColumns mixer.
// Latency: combinational, zero cycles.
// Backpressure: none; the owning engine sequences it.
module mix_column_lane
   import mix_columns_pkg::*;
#(
   parameter bit INV_EN = 1'b1
)(
   input  logic [0:31] col,
   input  logic        mode,
   output logic [0:31] mixed
);

   logic [0:31] fwd;

   assign fwd = mix_col(col, FWD_ROW);

   generate
      if (INV_EN) begin : g_inv
         logic [0:31] inv;
         assign inv   = mix_col(col, INV_ROW);
         assign mixed = mode ? inv : fwd;
      end else begin : g_fwd_only
         logic unused_mode;
         assign unused_mode = mode;
         assign mixed       = fwd;
      end
   endgenerate

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state, LANES columns per cycle.
// Latency: 4/LANES cycles from accept to out_valid; one block in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until drained.
module mix_columns_engine
   import mix_columns_pkg::*;
#(
   parameter int LANES  = 4,
   parameter bit INV_EN = 1'b1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [0:127] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data,
   output logic         busy
);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
         $error("mix_columns_engine: LANES must be 1, 2 or 4");
      end
   endgenerate

   // With LANES = 4 the step wraps to zero, so the counter simply stays at column 0.
   localparam logic [1:0] STEP = 2'(LANES % 4);
   localparam logic [1:0] LAST = 2'(4 - LANES);

   state_t       state_q;
   state_t       state_d;
   logic [1:0]   col_cnt;
   logic [0:127] blk_q;
   logic         mode_q;
   logic         accept;

   logic [1:0]   lane_idx [LANES];
   logic [0:31]  lane_col [LANES];
   logic [0:31]  lane_mix [LANES];

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (col_cnt == LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode registered state only; rst keeps in_ready low while asserted.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: in_ready = ~rst;
         RUN:  busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   assign out_data = blk_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = col_cnt + 2'(l);
      assign lane_col[l] = blk_q[{lane_idx[l], 5'd0} +: 32];

      mix_column_lane #(
         .INV_EN (INV_EN)
      ) u_lane (
         .col   (lane_col[l]),
         .mode  (mode_q),
         .mixed (lane_mix[l])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         blk_q   <= '0;
         mode_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            blk_q   <= in_data;
            mode_q  <= in_mode & INV_EN;
            col_cnt <= '0;
         end
      end else if (state_q == RUN) begin
         for (int l = 0; l < LANES; l++) begin
            blk_q[{lane_idx[l], 5'd0} +: 32] <= lane_mix[l];
         end
         col_cnt <= col_cnt + STEP;
      end
   end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench: four engines (LANES 4/2/1 with inverse, LANES 4 forward-only)
// driven one at a time; a negedge monitor pops expected results on each output handshake.
`timescale 1ns/1ps
module tb_mix_columns_engine;

   localparam int N = 4;
   localparam logic [127:0] V_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam logic [127:0] V_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] V_C6  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
   localparam int LAT [N] = '{1, 2, 4, 1};

   typedef struct {
      int           dut;
      logic [127:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid  [N];
   logic         in_ready  [N];
   logic         in_mode   [N];
   logic [127:0] in_data   [N];
   logic         out_valid [N];
   logic         out_ready [N] = '{default: 1'b1};
   logic [127:0] out_data  [N];
   logic         busy      [N];
   int           rdy_mode  [N] = '{default: 1};

   exp_t sb [$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mix_columns_engine #(
         .LANES  (g == 0 ? 4 : g == 1 ? 2 : g == 2 ? 1 : 4),
         .INV_EN (g != 3)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_mode   (in_mode[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g])
      );
   end

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Classic AES formulation: b_i = a_i ^ t ^ xtime(a_i ^ a_(i+1)), t = xor of the column.
   function automatic logic [127:0] model_fwd(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3, t;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         t  = a0 ^ a1 ^ a2 ^ a3;
         r[127-32*c -: 8] = a0 ^ t ^ xt(a0 ^ a1);
         r[119-32*c -: 8] = a1 ^ t ^ xt(a1 ^ a2);
         r[111-32*c -: 8] = a2 ^ t ^ xt(a2 ^ a3);
         r[103-32*c -: 8] = a3 ^ t ^ xt(a3 ^ a0);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Downstream ready: 0 = stalled, 1 = always ready, 2 = random throttling.
   always @(posedge clk) begin
      #2;
      for (int d = 0; d < N; d++) begin
         out_ready[d] = (rdy_mode[d] == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode[d] == 1);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < N; d++) begin
            if (out_valid[d] && out_ready[d]) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_output dut%0d: got %h, want no output", d, out_data[d]);
               end else begin
                  mon_e = sb.pop_front();
                  check($sformatf("sb_dut_index%0d", d), 128'(d), 128'(mon_e.dut));
                  check($sformatf("sb_data_dut%0d", d), out_data[d], mon_e.data);
               end
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int d, input logic [127:0] data, input logic mode,
                       input bit push, input logic [127:0] exp);
      int n;
      n = 0;
      in_data[d]  = data;
      in_mode[d]  = mode;
      in_valid[d] = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready[d]) break;
         n++;
         if (n > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d: got in_ready=0, want 1", d);
            break;
         end
      end
      if (push && n <= 200) sb.push_back('{dut: d, data: exp});
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_data[d]  = ~data;
      in_mode[d]  = ~mode;
   endtask

   task automatic wait_out(input int d, input int lat);
      int n;
      n = 0;
      while (!out_valid[d] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("latency_dut%0d", d), 128'(n), 128'(lat));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [127:0] x, y;
      int           n;
      for (int d = 0; d < N; d++) begin
         in_valid[d] = 1'b0;
         in_mode[d]  = 1'b0;
         in_data[d]  = '0;
      end

      idle_cycles(2);
      for (int d = 0; d < N; d++) begin
         check($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'(0));
         check($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
         check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
         check($sformatf("rst_out_data%0d", d), out_data[d], '0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < N; d++) check($sformatf("post_rst_in_ready%0d", d), 128'(in_ready[d]), 128'(1));
      idle_cycles(1);

      for (int d = 0; d < 3; d++) begin
         send(d, V_IN, 1'b0, 1'b1, V_OUT);
         wait_out(d, LAT[d]);
         send(d, V_OUT, 1'b1, 1'b1, V_IN);
         wait_out(d, LAT[d]);
      end
      send(3, V_IN, 1'b0, 1'b1, V_OUT);
      wait_out(3, LAT[3]);
      send(3, V_OUT, 1'b1, 1'b1, model_fwd(V_OUT));
      wait_out(3, LAT[3]);
      idle_cycles(2);

      // Back-pressure with a competing input that must be ignored.
      rdy_mode[0] = 0;
      send(0, V_IN, 1'b0, 1'b1, V_OUT);
      wait_out(0, LAT[0]);
      in_valid[0] = 1'b1;
      in_data[0]  = V_C6;
      in_mode[0]  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid[0]), 128'(1));
         check("bp_out_data", out_data[0], V_OUT);
         check("bp_in_ready", 128'(in_ready[0]), 128'(0));
         @(posedge clk);
         #1;
      end
      in_valid[0] = 1'b0;
      rdy_mode[0] = 1;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
      check("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
      check("bp_release_busy", 128'(busy[0]), 128'(0));
      idle_cycles(2);

      // Reset in the second RUN cycle of the LANES = 1 engine.
      send(2, V_IN, 1'b0, 1'b0, '0);
      idle_cycles(1);
      rst = 1'b1;
      #1;
      check("midrun_out_valid", 128'(out_valid[2]), 128'(0));
      check("midrun_busy", 128'(busy[2]), 128'(0));
      check("midrun_out_data", out_data[2], '0);
      check("midrun_in_ready", 128'(in_ready[2]), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrun_release_in_ready", 128'(in_ready[2]), 128'(1));
      idle_cycles(1);
      send(2, V_C6, 1'b0, 1'b1, V_C6);
      wait_out(2, LAT[2]);
      idle_cycles(2);

      // Random round trips with throttling on both sides.
      for (int k = 0; k < 3; k++) begin
         int d, cnt;
         d   = (k == 0) ? 2 : k - 1;
         cnt = (k == 0) ? 1000 : 200;
         rdy_mode[d] = 2;
         for (int i = 0; i < cnt; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = model_fwd(x);
            idle_cycles($urandom_range(0, 2));
            send(d, x, 1'b0, 1'b1, y);
            idle_cycles($urandom_range(0, 2));
            send(d, y, 1'b1, 1'b1, x);
         end
         n = 0;
         while (sb.size() != 0 && n < 100) begin
            idle_cycles(1);
            n++;
         end
         rdy_mode[d] = 1;
      end

      idle_cycles(3);
      check("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
